// File: rtl/dmem_lsu.sv
// Data-memory load/store unit.
// Takes one byte/half/word request at a time. Sub-word stores do a read-modify-write.
// Misaligned or illegal requests complete immediately with Fault and touch neither
// memory nor LoadData.
module dmem_lsu #(
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Req,
  output logic                     Ready,
  input  logic                     Op,
  input  logic [1:0]               Size,
  input  logic                     SignExt,
  input  logic [ADDRESS_WIDTH-1:0] Addr,
  input  logic [31:0]              StoreData,
  output logic [31:0]              LoadData,
  output logic                     Done,
  output logic                     Fault,
  output logic [ADDRESS_WIDTH-1:0] MemAddr,
  output logic [31:0]              MemWriteData,
  output logic                     MemWrite,
  input  logic [31:0]              MemReadData
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  state_e                   state_q;
  logic                     op_q;
  logic [1:0]               size_q;
  logic                     sext_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [31:0]              wdata_q;
  logic [31:0]              old_q;
  logic [31:0]              load_data_q;
  logic                     fault_q;

  logic                     req_fault;
  logic [7:0]               lane_byte;
  logic [15:0]              lane_half;
  logic [31:0]              load_word;
  logic [31:0]              merged;

  // Alignment / legality check on the incoming request.
  always_comb begin
    req_fault = 1'b0;
    case (Size)
      SizeByte: req_fault = 1'b0;
      SizeHalf: req_fault = Addr[0];
      SizeWord: req_fault = (Addr[1:0] != 2'b00);
      default:  req_fault = 1'b1;
    endcase
  end

  // Extract and extend the addressed lane of the word being read.
  always_comb begin
    lane_byte = MemReadData[{addr_q[1:0], 3'b000} +: 8];
    lane_half = addr_q[1] ? MemReadData[31:16] : MemReadData[15:0];
    case (size_q)
      SizeByte: load_word = {{24{sext_q & lane_byte[7]}}, lane_byte};
      SizeHalf: load_word = {{16{sext_q & lane_half[15]}}, lane_half};
      default:  load_word = MemReadData;
    endcase
  end

  // Replace the addressed lanes of the old word with the store operand.
  always_comb begin
    merged = old_q;
    case (size_q)
      SizeByte: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SizeHalf: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default:  merged = wdata_q;
    endcase
  end

  // Request sequencing: latch on acceptance, walk READ/WRITE as needed, one-cycle RESP.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      op_q        <= 1'b0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      old_q       <= 32'h0;
      load_data_q <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (Req) begin
            op_q    <= Op;
            size_q  <= Size;
            sext_q  <= SignExt;
            addr_q  <= Addr;
            wdata_q <= StoreData;
            fault_q <= req_fault;
            if (req_fault)                   state_q <= StResp;
            else if (Op && Size == SizeWord) state_q <= StWrite;
            else                             state_q <= StRead;
          end
        end
        StRead: begin
          if (op_q) begin
            old_q   <= MemReadData;
            state_q <= StWrite;
          end else begin
            load_data_q <= load_word;
            state_q     <= StResp;
          end
        end
        StWrite: state_q <= StResp;
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Ready        = (state_q == StIdle);
  assign Done         = (state_q == StResp);
  assign Fault        = (state_q == StResp) & fault_q;
  assign MemWrite     = (state_q == StWrite);
  assign MemAddr      = {2'b00, addr_q[ADDRESS_WIDTH-1:2]};
  assign MemWriteData = merged;
  assign LoadData     = load_data_q;

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, width of the byte address and of the memory-side word address.
REQ-002 SHALL have port Clk  in  1  the single clock; all state changes on posedge Clk.
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-004 SHALL have port Req  in  1  request strobe; accepted only when Ready=1.
REQ-005 SHALL have port Ready  out  1  high only in IDLE.
REQ-006 SHALL have port Op  in  1  0=load, 1=store.
REQ-007 SHALL have port Size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 SHALL have port SignExt  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-009 SHALL have port Addr  in  ADDRESS_WIDTH  byte address.
REQ-010 SHALL have port StoreData  in  32  store operand, right-aligned.
REQ-011 SHALL have port LoadData  out  32  registered load result.
REQ-012 SHALL have port Done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port Fault  out  1  high with Done for misaligned or illegal requests.
REQ-014 SHALL have port MemAddr  out  ADDRESS_WIDTH  word address to data memory = {2'b00, latched Addr[AW-1:2]}.
REQ-015 SHALL have port MemWriteData  out  32  merged word to data memory.
REQ-016 SHALL have port MemWrite  out  1  data-memory write enable, decoded from state.
REQ-017 SHALL have port MemReadData  in  32  combinational read data from data memory at MemAddr.

Function
REQ-018 SHALL latch Op, Size, SignExt, Addr, StoreData on the edge where Req=1 and Ready=1; Req at any other time is ignored.
REQ-019 SHALL implement states IDLE, READ, WRITE, RESP; only IDLE/READ/WRITE/RESP are reachable.
REQ-020 SHALL treat as fault: Size=11; half with Addr[0]=1; word with Addr[1:0]!=00; a faulting request goes IDLE->RESP with Fault=1, no MemWrite, LoadData unchanged.
REQ-021 Load: IDLE->READ->RESP; LoadData captured from MemReadData at the READ->RESP edge; Done high the 2nd cycle after acceptance.
REQ-022 Word store: IDLE->WRITE->RESP; MemWriteData=StoreData, MemWrite=1 for exactly the WRITE cycle; Done 2nd cycle after acceptance.
REQ-023 Byte/half store: IDLE->READ->WRITE->RESP; old word captured in READ, lanes replaced in WRITE; Done 3rd cycle after acceptance.
REQ-024 SHALL use little-endian lanes: byte k=Addr[1:0] at bits [8k+7:8k]; half at bits [15:0] if Addr[1]=0 else [31:16]; non-selected lanes preserved bit-exact.
REQ-025 Sub-word load SHALL extract the selected lane into bits low, upper bits = lane MSB if SignExt=1 else 0; word load ignores SignExt.
REQ-026 RESP SHALL last one cycle then return to IDLE; Done and Fault are low in all other states.
REQ-027 LoadData SHALL hold its value until the next successful load; stores and faults never modify it.
REQ-028 MemWrite SHALL be 0 in IDLE, READ, RESP; MemAddr stays at the latched word address until the next acceptance.

Reset
REQ-029 Reset=1 at an edge SHALL force IDLE and clear latched request, LoadData, Done, Fault to 0; Ready=1, MemWrite=0, MemAddr=0 the following cycle.
REQ-030 Reset mid-operation SHALL abort without Done; if asserted during WRITE, the write on that edge still occurs (MemWrite already high), no further writes follow.
REQ-031 Reset SHALL take priority over Req on the same edge.

Verification
REQ-032 Word store Addr=0x10, StoreData=0xDEADBEEF, then word load 0x10 -> MemAddr=0x4, one MemWrite pulse, LoadData=0xDEADBEEF, Done 2 cycles after each accept.
REQ-033 Memory word at 0x10=0x11223344; byte store 0xAA to Addr=0x12 -> word becomes 0x11AA3344, Done 3 cycles after accept, MemWrite exactly 1 cycle.
REQ-034 Word 0x8000FF80 at 0x20: byte load 0x20 SignExt=1 -> 0xFFFFFF80; SignExt=0 -> 0x00000080; half load 0x22 SignExt=1 -> 0xFFFF8000.
REQ-035 Half load Addr=0x21, word store Addr=0x22, Size=11 -> each Done+Fault 1 cycle after accept, MemWrite never high, LoadData unchanged.
REQ-036 Reset asserted in READ of a byte store -> no MemWrite, no Done, Ready=1 next cycle; Req held high during busy cycles accepted only once.
